// File: rtl/alsu_pkg.sv
// Shared types and default sizes for the pipelined ALSU.
package alsu_pkg;

  typedef enum logic [2:0] {
    OR        = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    INVALID_6 = 3'd6,
    INVALID_7 = 3'd7
  } opcode_e;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_LED_W = 16;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/alsu_core.sv
// Combinational ALSU datapath: invalid-op decode, bypass selection and opcode result,
// evaluated from the stage-1 registers and the current output register.
module alsu_core
  import alsu_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int FULL_ADDER     = 1,
  parameter     INPUT_PRIORITY = "A"
) (
  input  opcode_e                  opcode_i,
  input  logic signed [WIDTH-1:0]  a_i,
  input  logic signed [WIDTH-1:0]  b_i,
  input  logic                     cin_i,
  input  logic                     red_op_a_i,
  input  logic                     red_op_b_i,
  input  logic                     bypass_a_i,
  input  logic                     bypass_b_i,
  input  logic                     direction_i,
  input  logic                     serial_in_i,
  input  logic [2*WIDTH-1:0]       cur_out_i,
  output logic [2*WIDTH-1:0]       result_o,
  output logic                     invalid_o
);

  localparam int OW = 2 * WIDTH;

  logic [OW-1:0]        a_ext, b_ext, or_ext, xor_ext, sum, cin_ext;
  logic signed [OW-1:0] prod;
  logic [WIDTH-1:0]     or_ab, xor_ab;
  logic                 cin_used;

  assign a_ext    = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign b_ext    = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign or_ab    = a_i | b_i;
  assign xor_ab   = a_i ^ b_i;
  assign or_ext   = {{WIDTH{or_ab[WIDTH-1]}}, or_ab};
  assign xor_ext  = {{WIDTH{xor_ab[WIDTH-1]}}, xor_ab};
  assign cin_used = (FULL_ADDER != 0) ? cin_i : 1'b0;
  assign cin_ext  = {{(OW-1){1'b0}}, cin_used};
  // Operands are sign-extended to 2*WIDTH, so neither sum nor product can overflow.
  assign sum      = a_ext + b_ext + cin_ext;
  assign prod     = $signed(a_ext) * $signed(b_ext);

  always_comb begin
    result_o  = '0;
    invalid_o = 1'b0;
    if (opcode_i == INVALID_6 || opcode_i == INVALID_7 ||
        ((red_op_a_i || red_op_b_i) && opcode_i != OR && opcode_i != XOR)) begin
      invalid_o = 1'b1;
    end else if (bypass_a_i && bypass_b_i) begin
      result_o = (INPUT_PRIORITY == "B") ? b_ext : a_ext;
    end else if (bypass_a_i) begin
      result_o = a_ext;
    end else if (bypass_b_i) begin
      result_o = b_ext;
    end else begin
      case (opcode_i)
        OR: begin
          if (red_op_a_i)      result_o = {{(OW-1){1'b0}}, |a_i};
          else if (red_op_b_i) result_o = {{(OW-1){1'b0}}, |b_i};
          else                 result_o = or_ext;
        end
        XOR: begin
          if (red_op_a_i)      result_o = {{(OW-1){1'b0}}, ^a_i};
          else if (red_op_b_i) result_o = {{(OW-1){1'b0}}, ^b_i};
          else                 result_o = xor_ext;
        end
        ADD:  result_o = sum;
        MULT: result_o = prod;
        SHIFT: result_o = direction_i ? {cur_out_i[OW-2:0], serial_in_i}
                                      : {serial_in_i, cur_out_i[OW-1:1]};
        ROTATE: result_o = direction_i ? {cur_out_i[OW-2:0], cur_out_i[OW-1]}
                                       : {cur_out_i[0], cur_out_i[OW-1:1]};
        default: result_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alsu_pipe.sv
// Two-stage ALSU: stage 1 registers qualified inputs, stage 2 updates out/leds/err_cnt.
// Handshake: in_valid qualifies inputs each cycle; out_valid pulses two edges later; no backpressure.
module alsu_pipe
  import alsu_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int LED_W          = DEF_LED_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int FULL_ADDER     = 1,
  parameter     INPUT_PRIORITY = "A"
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      cin,
  input  logic                      red_op_A,
  input  logic                      red_op_B,
  input  logic                      bypass_A,
  input  logic                      bypass_B,
  input  logic                      direction,
  input  logic                      serial_in,
  input  logic [2:0]                opcode,
  input  logic signed [WIDTH-1:0]   A,
  input  logic signed [WIDTH-1:0]   B,
  output logic                      out_valid,
  output logic signed [2*WIDTH-1:0] out,
  output logic [LED_W-1:0]          leds,
  output logic [CNT_W-1:0]          err_cnt
);

  opcode_e                 s1_op_q;
  logic signed [WIDTH-1:0] s1_a_q, s1_b_q;
  logic                    s1_cin_q, s1_red_a_q, s1_red_b_q, s1_byp_a_q, s1_byp_b_q;
  logic                    s1_dir_q, s1_si_q, s1_valid_q;

  logic [2*WIDTH-1:0] out_q, out_d, result;
  logic [LED_W-1:0]   leds_q, leds_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               out_valid_q, invalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_op_q    <= OR;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_red_a_q <= 1'b0;
      s1_red_b_q <= 1'b0;
      s1_byp_a_q <= 1'b0;
      s1_byp_b_q <= 1'b0;
      s1_dir_q   <= 1'b0;
      s1_si_q    <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op_q    <= opcode_e'(opcode);
        s1_a_q     <= A;
        s1_b_q     <= B;
        s1_cin_q   <= cin;
        s1_red_a_q <= red_op_A;
        s1_red_b_q <= red_op_B;
        s1_byp_a_q <= bypass_A;
        s1_byp_b_q <= bypass_B;
        s1_dir_q   <= direction;
        s1_si_q    <= serial_in;
      end
    end
  end

  alsu_core #(
    .WIDTH          (WIDTH),
    .FULL_ADDER     (FULL_ADDER),
    .INPUT_PRIORITY (INPUT_PRIORITY)
  ) u_core (
    .opcode_i    (s1_op_q),
    .a_i         (s1_a_q),
    .b_i         (s1_b_q),
    .cin_i       (s1_cin_q),
    .red_op_a_i  (s1_red_a_q),
    .red_op_b_i  (s1_red_b_q),
    .bypass_a_i  (s1_byp_a_q),
    .bypass_b_i  (s1_byp_b_q),
    .direction_i (s1_dir_q),
    .serial_in_i (s1_si_q),
    .cur_out_i   (out_q),
    .result_o    (result),
    .invalid_o   (invalid)
  );

  // Bubbles hold out/leds/err_cnt so SHIFT/ROTATE always see the last valid result.
  always_comb begin
    out_d     = out_q;
    leds_d    = leds_q;
    err_cnt_d = err_cnt_q;
    if (s1_valid_q) begin
      if (invalid) begin
        out_d  = '0;
        leds_d = ~leds_q;
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
      end else begin
        out_d  = result;
        leds_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      leds_q      <= '0;
      err_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      leds_q      <= leds_d;
      err_cnt_q   <= err_cnt_d;
      out_valid_q <= s1_valid_q;
    end
  end

  assign out       = out_q;
  assign leds      = leds_q;
  assign err_cnt   = err_cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alsu_pipe.sv
// Scoreboard bench for alsu_pipe: default instance plus a FULL_ADDER=0 / priority "B" instance.
module tb_alsu_pipe;
  import alsu_pkg::*;

  localparam logic [6:0] F_CIN = 7'b1000000;
  localparam logic [6:0] F_RA  = 7'b0100000;
  localparam logic [6:0] F_RB  = 7'b0010000;
  localparam logic [6:0] F_BA  = 7'b0001000;
  localparam logic [6:0] F_BB  = 7'b0000100;
  localparam logic [6:0] F_DIR = 7'b0000010;
  localparam logic [6:0] F_SI  = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in;
  logic [2:0]  opcode, A, B;
  logic        out_valid, out_valid0;
  logic [5:0]  out, out0;
  logic [15:0] leds, leds0;
  logic [7:0]  err_cnt, err_cnt0;

  logic [29:0] exp_q[$];
  logic [29:0] exp0_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alsu_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cin(cin),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .direction(direction), .serial_in(serial_in), .opcode(opcode), .A(A), .B(B),
    .out_valid(out_valid), .out(out), .leds(leds), .err_cnt(err_cnt)
  );

  alsu_pipe #(.FULL_ADDER(0), .INPUT_PRIORITY("B")) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cin(cin),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .direction(direction), .serial_in(serial_in), .opcode(opcode), .A(A), .B(B),
    .out_valid(out_valid0), .out(out0), .leds(leds0), .err_cnt(err_cnt0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per out_valid, per instance.
  always @(negedge clk) begin
    logic [29:0] e;
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut unexpected out_valid out=%h", out);
      end else begin
        e = exp_q.pop_front();
        check("dut out", 32'(out), 32'(e[29:24]));
        check("dut leds", 32'(leds), 32'(e[23:8]));
        check("dut err_cnt", 32'(err_cnt), 32'(e[7:0]));
      end
    end
    if (rst === 1'b1 && out_valid0 === 1'b1) begin
      if (exp0_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected out_valid out=%h", out0);
      end else begin
        e = exp0_q.pop_front();
        check("dut0 out", 32'(out0), 32'(e[29:24]));
        check("dut0 leds", 32'(leds0), 32'(e[23:8]));
        check("dut0 err_cnt", 32'(err_cnt0), 32'(e[7:0]));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                      input logic [6:0] f, input logic [5:0] e, input logic [5:0] e0,
                      input logic [15:0] el, input logic [7:0] ec);
    @(negedge clk);
    opcode = op; A = a; B = b;
    {cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in} = f;
    in_valid = 1'b1;
    exp_q.push_back({e, el, ec});
    exp0_q.push_back({e0, el, ec});
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    {cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in} = '0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp0_q.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
    check("drain pending", 32'(exp_q.size() + exp0_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " out"}, 32'(out), 32'd0);
    check({tag, " leds"}, 32'(leds), 32'd0);
    check({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " out0"}, 32'(out0), 32'd0);
    check({tag, " out_valid0"}, 32'(out_valid0), 32'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; opcode = '0; A = '0; B = '0;
    {cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in} = '0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    send(ADD,    3'd3,    3'd2,    F_CIN,        6'h06, 6'h05, 16'h0000, 8'd0);
    send(SHIFT,  3'd0,    3'd0,    F_DIR | F_SI, 6'h0D, 6'h0B, 16'h0000, 8'd0);
    send(MULT,   3'b100,  3'b100,  7'd0,         6'h10, 6'h10, 16'h0000, 8'd0);
    send(MULT,   3'b011,  3'b100,  7'd0,         6'h34, 6'h34, 16'h0000, 8'd0);
    send(OR,     3'b001,  3'b010,  7'd0,         6'h03, 6'h03, 16'h0000, 8'd0);
    idle();
    send(OR,     3'd0,    3'b001,  F_BB,         6'h01, 6'h01, 16'h0000, 8'd0);
    send(ROTATE, 3'd0,    3'd0,    7'd0,         6'h20, 6'h20, 16'h0000, 8'd0);
    send(ROTATE, 3'd0,    3'd0,    F_DIR,        6'h01, 6'h01, 16'h0000, 8'd0);
    send(ADD,    3'b110,  3'b001,  F_BA | F_BB,  6'h3E, 6'h01, 16'h0000, 8'd0);
    send(XOR,    3'b011,  3'd0,    F_RA,         6'h00, 6'h00, 16'h0000, 8'd0);
    send(OR,     3'b100,  3'd0,    F_RA,         6'h01, 6'h01, 16'h0000, 8'd0);
    send(XOR,    3'b011,  3'b001,  F_RA | F_RB,  6'h00, 6'h00, 16'h0000, 8'd0);
    send(XOR,    3'b101,  3'b011,  7'd0,         6'h3E, 6'h3E, 16'h0000, 8'd0);
    send(SHIFT,  3'd0,    3'd0,    7'd0,         6'h1F, 6'h1F, 16'h0000, 8'd0);
    send(INVALID_6, 3'd1, 3'd1,    7'd0,         6'h00, 6'h00, 16'hFFFF, 8'd1);
    send(INVALID_6, 3'd1, 3'd1,    7'd0,         6'h00, 6'h00, 16'h0000, 8'd2);
    send(INVALID_6, 3'd1, 3'd1,    7'd0,         6'h00, 6'h00, 16'hFFFF, 8'd3);
    send(OR,     3'b001,  3'd0,    7'd0,         6'h01, 6'h01, 16'h0000, 8'd3);
    send(ADD,    3'd1,    3'd1,    F_RB,         6'h00, 6'h00, 16'hFFFF, 8'd4);
    send(INVALID_7, 3'd0, 3'd0,    7'd0,         6'h00, 6'h00, 16'h0000, 8'd5);
    send(ADD,    3'b100,  3'b100,  F_CIN,        6'h39, 6'h38, 16'h0000, 8'd5);
    drain();

    // Reset while an op sits in stage 1: it must never emerge.
    @(negedge clk);
    opcode = ADD; A = 3'd1; B = 3'd1; in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_zero("mid reset");
    exp_q.delete();
    exp0_q.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("post reset out_valid", 32'(out_valid), 32'd0);
      check("post reset out_valid0", 32'(out_valid0), 32'd0);
    end
    send(SHIFT, 3'd0, 3'd0, F_DIR | F_SI, 6'h01, 6'h01, 16'h0000, 8'd0);

    for (int i = 1; i <= 256; i++) begin
      send(INVALID_6, 3'd0, 3'd0, 7'd0, 6'h00, 6'h00,
           (i % 2 == 1) ? 16'hFFFF : 16'h0000, (i > 255) ? 8'd255 : 8'(i));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
